uartlite_fifo_bridge: RTL and testbench

UARTLITE_FIFO_BRIDGE -- requirements
Module: uartlite_fifo_bridge

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uartlite_fifo_bridge_if.sv | 37 +++
 rtl/uart_sync_fifo.sv | 57 +++++
 rtl/uartlite_fifo_bridge.sv | 189 ++++++++++++++++++
 tb/tb_uartlite_fifo_bridge.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UartLite FIFO bridge: register map, STAT bit
// positions and the poll/transfer state encoding.
package uart_pkg;

    localparam logic [7:0] REG_RX   = 8'h0;
    localparam logic [7:0] REG_TX   = 8'h4;
    localparam logic [7:0] REG_STAT = 8'h8;
    localparam logic [7:0] REG_CTRL = 8'hC;

    localparam int unsigned STAT_RXV = 0;
    localparam int unsigned STAT_TXF = 3;

    typedef enum logic [2:0] {
        IDLE,
        STAT_AR,
        STAT_R,
        RX_AR,
        RX_R,
        TX_AW,
        TX_B
    } state_t;

endpackage

// File: rtl/uartlite_fifo_bridge_if.sv
// AXI4-Lite bus between the FIFO bridge (master) and the UartLite core (slave).
interface uartlite_fifo_bridge_if #(
    parameter int unsigned ADDR_W = 4
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO without fall-through; a push on a full FIFO is accepted
// only together with a pop, a pop on an empty FIFO is ignored.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   lvl_t;

    localparam lvl_t FULL_LVL = lvl_t'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + lvl_t'(1);
                2'b01:   level <= level - lvl_t'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uartlite_fifo_bridge.sv
// Byte-stream <-> UartLite bridge: polls STAT, then moves one byte per poll.
// Optional error counter on non-OKAY responses: define UARTLITE_ERR_CNT_EN.
module uartlite_fifo_bridge
    import uart_pkg::*;
#(
    parameter int unsigned TX_DEPTH   = 16,
    parameter int unsigned RX_DEPTH   = 16,
    parameter int unsigned AXI_ADDR_W = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [7:0]                  t_data,
    input  logic                        t_valid,
    output logic                        t_ready,
    output logic [7:0]                  r_data,
    output logic                        r_valid,
    input  logic                        r_ready,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    uartlite_fifo_bridge_if.master      axi
`ifdef UARTLITE_ERR_CNT_EN
    ,
    output logic [15:0]                 err_cnt,
    output logic                        err_flag
`endif
);

    typedef logic [AXI_ADDR_W-1:0] addr_t;

    state_t     state;
    state_t     state_next;
    logic       aw_done;
    logic       w_done;

    logic       tx_push;
    logic       tx_pop;
    logic       tx_full;
    logic       tx_empty;
    logic [7:0] tx_head;

    logic       rx_push;
    logic       rx_pop;
    logic       rx_full;
    logic       rx_empty;

    assign t_ready = rstn && !tx_full;
    assign tx_push = t_valid && t_ready;
    assign r_valid = !rx_empty;
    assign rx_pop  = r_valid && r_ready;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (tx_push),
        .wdata (t_data),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (rx_push),
        .wdata (axi.rdata[7:0]),
        .pop   (rx_pop),
        .rdata (r_data),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    // aw_done/w_done let AW and W complete in either order while in TX_AW.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == TX_AW) begin
                if (axi.awvalid && axi.awready) aw_done <= 1'b1;
                if (axi.wvalid && axi.wready)   w_done  <= 1'b1;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next  = state;
        axi.arvalid = 1'b0;
        axi.araddr  = '0;
        axi.rready  = 1'b0;
        axi.awvalid = 1'b0;
        axi.awaddr  = '0;
        axi.wvalid  = 1'b0;
        axi.wdata   = '0;
        axi.wstrb   = '0;
        axi.bready  = 1'b0;
        rx_push     = 1'b0;
        tx_pop      = 1'b0;

        case (state)
            IDLE: state_next = STAT_AR;

            STAT_AR: begin
                axi.arvalid = 1'b1;
                axi.araddr  = addr_t'(REG_STAT);
                if (axi.arready) state_next = STAT_R;
            end

            // RX service takes priority over TX so incoming bytes are not dropped.
            STAT_R: begin
                axi.rready = 1'b1;
                if (axi.rvalid) begin
                    if (axi.rdata[STAT_RXV] && !rx_full)
                        state_next = RX_AR;
                    else if (!tx_empty && !axi.rdata[STAT_TXF])
                        state_next = TX_AW;
                    else
                        state_next = IDLE;
                end
            end

            RX_AR: begin
                axi.arvalid = 1'b1;
                axi.araddr  = addr_t'(REG_RX);
                if (axi.arready) state_next = RX_R;
            end

            RX_R: begin
                axi.rready = 1'b1;
                if (axi.rvalid) begin
                    rx_push    = 1'b1;
                    state_next = IDLE;
                end
            end

            TX_AW: begin
                axi.awvalid = !aw_done;
                axi.wvalid  = !w_done;
                axi.awaddr  = addr_t'(REG_TX);
                axi.wdata   = {24'b0, tx_head};
                axi.wstrb   = 4'b0001;
                if ((aw_done || axi.awready) && (w_done || axi.wready))
                    state_next = TX_B;
            end

            // The head byte leaves the FIFO only once the write is acknowledged.
            TX_B: begin
                axi.bready = 1'b1;
                if (axi.bvalid) begin
                    tx_pop     = 1'b1;
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

`ifdef UARTLITE_ERR_CNT_EN
    logic err_evt;

    assign err_evt = (axi.rvalid && axi.rready && (axi.rresp != 2'b00)) ||
                     (axi.bvalid && axi.bready && (axi.bresp != 2'b00));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else if (err_evt) begin
            if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
            err_flag <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uartlite_fifo_bridge.sv
// Bench for uartlite_fifo_bridge: reactive UartLite slave, queue-based model
// of both FIFOs and the poll decision, plus directed scenarios.
`timescale 1ns/1ps
module tb_uartlite_fifo_bridge;

    localparam int unsigned TXD = 16;
    localparam int unsigned RXD = 16;
    localparam int unsigned AW  = 4;

    localparam int K_STAT = 0;
    localparam int K_RX   = 1;
    localparam int K_WR   = 2;

    localparam int A_S = 0;
    localparam int A_R = 1;
    localparam int A_W = 2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] t_data = 8'h00;
    logic       t_valid = 1'b0;
    logic       t_ready;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_ready = 1'b0;
    logic [4:0] tx_level;
    logic [4:0] rx_level;
`ifdef UARTLITE_ERR_CNT_EN
    logic [15:0] err_cnt;
    logic        err_flag;
`endif

    always #5 clk = ~clk;

    uartlite_fifo_bridge_if #(.ADDR_W(AW)) axi ();

    uartlite_fifo_bridge #(
        .TX_DEPTH   (TXD),
        .RX_DEPTH   (RXD),
        .AXI_ADDR_W (AW)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .t_data   (t_data),
        .t_valid  (t_valid),
        .t_ready  (t_ready),
        .r_data   (r_data),
        .r_valid  (r_valid),
        .r_ready  (r_ready),
        .tx_level (tx_level),
        .rx_level (rx_level),
        .axi      (axi)
`ifdef UARTLITE_ERR_CNT_EN
        ,
        .err_cnt  (err_cnt),
        .err_flag (err_flag)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] wr_log[$];
    int         acc_log[$];
    int         exp_kind = K_STAT;
    int         n_aw = 0;
    int         n_b = 0;
    int         err_model = 0;
    int         aw_hi = 0;
    int         w_hi = 0;

    // Slave state and configuration
    logic [7:0]    rx_src[$];
    bit            rd_pend = 0;
    logic [AW-1:0] rd_addr = '0;
    bit            aw_seen = 0;
    bit            w_seen = 0;
    int            aw_wait = 0;
    int            aw_delay = 0;
    bit            b_hold = 0;
    logic [1:0]    bresp_cfg = 2'b00;
    bit            txf_flag = 0;
    bit            txf_clear_on_rx = 0;

    bit            ar_p = 0, aw_p = 0, w_p = 0;
    logic [AW-1:0] ar_a, aw_a;
    logic [31:0]   w_a;
    int            tx_n, rx_n;

    // Slave drives its side of the bus away from the active edge.
    always @(negedge clk) begin
        axi.arready = !rd_pend;
        axi.rvalid  = rd_pend;
        if (rd_addr == AW'(8))
            axi.rdata = {24'b0, 4'b0, txf_flag, 2'b0, (rx_src.size() > 0)};
        else
            axi.rdata = {24'b0, (rx_src.size() > 0) ? rx_src[0] : 8'h00};
        axi.rresp   = 2'b00;
        axi.awready = !aw_seen && (aw_wait >= aw_delay);
        axi.wready  = !w_seen;
        axi.bvalid  = aw_seen && w_seen && !b_hold;
        axi.bresp   = bresp_cfg;
    end

    // Handshake observer and model update on the active edge.
    always @(posedge clk) begin
        if (!rstn) begin
            tx_q.delete();
            rx_q.delete();
            exp_kind  = K_STAT;
            rd_pend   = 0;
            aw_seen   = 0;
            w_seen    = 0;
            aw_wait   = 0;
            ar_p      = 0;
            aw_p      = 0;
            w_p       = 0;
            err_model = 0;
        end else begin
            tx_n = tx_q.size();
            rx_n = rx_q.size();

            if (ar_p) check("ar_stable", {31'b0, axi.arvalid}, 32'h1);
            if (ar_p) check("ar_addr_stable", 32'(axi.araddr), 32'(ar_a));
            if (aw_p) check("aw_stable", {31'b0, axi.awvalid}, 32'h1);
            if (w_p)  check("w_stable", {31'b0, axi.wvalid}, 32'h1);
            if (w_p)  check("w_data_stable", axi.wdata, w_a);

            if (axi.awvalid) aw_hi++;
            if (axi.wvalid)  w_hi++;

            if (t_valid && tx_n < TXD) tx_q.push_back(t_data);
            if (r_ready && rx_n > 0)   void'(rx_q.pop_front());

            if (axi.arvalid && axi.arready) begin
                check("ar_when_write_due", {31'b0, exp_kind != K_WR}, 32'h1);
                check("ar_addr", 32'(axi.araddr), (exp_kind == K_RX) ? 32'h0 : 32'h8);
                rd_pend = 1;
                rd_addr = axi.araddr;
                acc_log.push_back((axi.araddr == '0) ? A_R : A_S);
            end
            ar_p = axi.arvalid && !axi.arready;
            ar_a = axi.araddr;

            if (axi.rvalid && axi.rready) begin
                if (axi.rresp != 2'b00 && err_model < 65535) err_model++;
                if (rd_addr == AW'(8)) begin
                    if (axi.rdata[0] && rx_n < RXD)      exp_kind = K_RX;
                    else if (tx_n > 0 && !axi.rdata[3])  exp_kind = K_WR;
                    else                                 exp_kind = K_STAT;
                end else begin
                    rx_q.push_back(axi.rdata[7:0]);
                    exp_kind = K_STAT;
                    if (rx_src.size() > 0) void'(rx_src.pop_front());
                    if (txf_clear_on_rx) begin
                        txf_flag        = 0;
                        txf_clear_on_rx = 0;
                    end
                end
                rd_pend = 0;
            end

            if (axi.awvalid && axi.awready) begin
                check("aw_when_due", {31'b0, exp_kind == K_WR}, 32'h1);
                check("aw_addr", 32'(axi.awaddr), 32'h4);
                aw_seen = 1;
                aw_wait = 0;
                n_aw++;
                acc_log.push_back(A_W);
            end else if (axi.awvalid) begin
                aw_wait++;
            end
            aw_p = axi.awvalid && !axi.awready;

            if (axi.wvalid && axi.wready) begin
                if (tx_n > 0) check("w_data", axi.wdata, {24'b0, tx_q[0]});
                else          check("w_with_empty_fifo", 32'h1, 32'h0);
                check("w_strb", {28'b0, axi.wstrb}, 32'h1);
                wr_log.push_back(axi.wdata[7:0]);
                w_seen = 1;
            end
            w_p = axi.wvalid && !axi.wready;
            w_a = axi.wdata;

            if (axi.bvalid && axi.bready) begin
                if (axi.bresp != 2'b00 && err_model < 65535) err_model++;
                if (tx_q.size() > 0) void'(tx_q.pop_front());
                exp_kind = K_STAT;
                aw_seen  = 0;
                w_seen   = 0;
                n_b++;
            end
        end
    end

    // Per-cycle comparison of the stream-side outputs against the model.
    always @(posedge clk) begin
        #2;
        check("t_ready", {31'b0, t_ready}, {31'b0, rstn && (tx_q.size() < TXD)});
        check("tx_level", 32'(tx_level), 32'(tx_q.size()));
        check("rx_level", 32'(rx_level), 32'(rx_q.size()));
        check("r_valid", {31'b0, r_valid}, {31'b0, rx_q.size() > 0});
        if (rx_q.size() > 0) check("r_data", 32'(r_data), 32'(rx_q[0]));
`ifdef UARTLITE_ERR_CNT_EN
        check("err_cnt", 32'(err_cnt), 32'(err_model));
        check("err_flag", {31'b0, err_flag}, {31'b0, err_model > 0});
`endif
    end

    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        while (!t_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            check("push_timeout", 32'h0, 32'h1);
        end else begin
            t_valid = 1'b1;
            t_data  = b;
            @(negedge clk);
            t_valid = 1'b0;
        end
    endtask

    task automatic wait_b(input int target);
        int n = 0;
        while (n_b < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("wait_b_done", {31'b0, n_b >= target}, 32'h1);
    endtask

    task automatic wait_rvalid();
        int n = 0;
        while (!r_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("wait_rvalid_done", {31'b0, r_valid}, 32'h1);
    endtask

    logic [7:0] exp31 [3] = '{8'h41, 8'h42, 8'h43};
    int log0, w0, b0, aw0, idx, nw;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_t_ready", {31'b0, t_ready}, 32'h0);
        check("rst_r_valid", {31'b0, r_valid}, 32'h0);
        check("rst_tx_level", 32'(tx_level), 32'h0);
        check("rst_rx_level", 32'(rx_level), 32'h0);
        check("rst_arvalid", {31'b0, axi.arvalid}, 32'h0);
        check("rst_awvalid", {31'b0, axi.awvalid}, 32'h0);
        check("rst_wvalid", {31'b0, axi.wvalid}, 32'h0);
        check("rst_rready", {31'b0, axi.rready}, 32'h0);
        check("rst_bready", {31'b0, axi.bready}, 32'h0);
        check("rst_araddr", 32'(axi.araddr), 32'h0);
        rstn = 1'b1;
        @(negedge clk);
        check("t_ready_after_release", {31'b0, t_ready}, 32'h1);

        // Three TX bytes, each written after its own STAT poll
        log0 = acc_log.size();
        w0   = wr_log.size();
        b0   = n_b;
        push_byte(8'h41);
        push_byte(8'h42);
        push_byte(8'h43);
        wait_b(b0 + 3);
        for (int i = 0; i < 3; i++) begin
            if (wr_log.size() > w0 + i) check("tx_order", 32'(wr_log[w0 + i]), 32'(exp31[i]));
            else                        check("tx_order_missing", 32'h0, 32'h1);
        end
        nw = 0;
        for (int i = log0; i < acc_log.size(); i++) begin
            if (acc_log[i] == A_W) begin
                nw++;
                if (i > 0) check("w_after_stat", 32'(acc_log[i - 1]), 32'(A_S));
            end
        end
        check("tx_write_count", 32'(nw), 32'd3);
        check("tx_drained", 32'(tx_level), 32'h0);

        // One RX byte, consumer stalled
        rx_src.push_back(8'h5A);
        wait_rvalid();
        check("rx_r_valid", {31'b0, r_valid}, 32'h1);
        check("rx_r_data", 32'(r_data), 32'h5A);
        check("rx_level_one", 32'(rx_level), 32'h1);
        repeat (20) @(negedge clk);
        check("rx_level_hold", 32'(rx_level), 32'h1);
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        check("rx_drained", 32'(rx_level), 32'h0);
        check("rx_valid_drained", {31'b0, r_valid}, 32'h0);

        // STAT=0x09 with TX pending: RX read wins, write on the following poll
        txf_flag = 1;
        aw0 = n_aw;
        b0  = n_b;
        push_byte(8'h77);
        repeat (12) @(negedge clk);
        check("no_aw_while_txf", 32'(n_aw), 32'(aw0));
        log0 = acc_log.size();
        txf_clear_on_rx = 1;
        rx_src.push_back(8'h33);
        wait_b(b0 + 1);
        idx = -1;
        for (int i = log0; i < acc_log.size(); i++) begin
            if (idx < 0 && acc_log[i] == A_R) idx = i;
        end
        if (idx >= 0 && idx + 2 < acc_log.size()) begin
            check("prio_poll_after_rx", 32'(acc_log[idx + 1]), 32'(A_S));
            check("prio_write_after_poll", 32'(acc_log[idx + 2]), 32'(A_W));
        end else begin
            check("prio_sequence_missing", 32'h0, 32'h1);
        end
        check("prio_rx_byte", 32'(r_data), 32'h33);
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;

        // Fill TX while UartLite reports TX full
        txf_flag = 1;
        aw0 = n_aw;
        b0  = n_b;
        w0  = wr_log.size();
        for (int i = 0; i < TXD; i++) push_byte(8'h80 + 8'(i));
        check("full_t_ready", {31'b0, t_ready}, 32'h0);
        check("full_tx_level", 32'(tx_level), 32'd16);
        check("full_no_aw", 32'(n_aw), 32'(aw0));
        txf_flag = 0;
        wait_b(b0 + TXD);
        for (int i = 0; i < TXD; i++) begin
            if (wr_log.size() > w0 + i) check("full_order", 32'(wr_log[w0 + i]), 32'h80 + 32'(i));
        end
        check("full_resumed_ready", {31'b0, t_ready}, 32'h1);

        // AW accepted after 5 wait cycles, W immediately
        aw_delay = 5;
        b0 = n_b;
        @(negedge clk);
        aw_hi = 0;
        w_hi  = 0;
        push_byte(8'hC5);
        wait_b(b0 + 1);
        repeat (3) @(negedge clk);
        check("slow_aw_wvalid_cycles", 32'(w_hi), 32'd1);
        check("slow_aw_awvalid_cycles", 32'(aw_hi), 32'd6);
        check("slow_aw_single_pop", 32'(n_b - b0), 32'd1);
        check("slow_aw_level", 32'(tx_level), 32'h0);
        check("slow_aw_data", 32'(wr_log[wr_log.size() - 1]), 32'hC5);
        aw_delay = 0;

        // Reset while waiting for B, then two error responses
        b_hold = 1;
        push_byte(8'h99);
        begin
            int n = 0;
            while (!axi.bready && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        check("reached_tx_b", {31'b0, axi.bready}, 32'h1);
        check("held_byte_kept", 32'(tx_level), 32'h1);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        b_hold = 0;
        check("midrst_t_ready", {31'b0, t_ready}, 32'h0);
        check("midrst_bready", {31'b0, axi.bready}, 32'h0);
        rstn = 1'b1;
        @(negedge clk);
        check("midrst_tx_level", 32'(tx_level), 32'h0);
        check("midrst_rx_level", 32'(rx_level), 32'h0);
        check("midrst_t_ready_after", {31'b0, t_ready}, 32'h1);
        bresp_cfg = 2'b10;
        b0 = n_b;
        push_byte(8'hE1);
        push_byte(8'hE2);
        wait_b(b0 + 2);
        check("err_tx_level", 32'(tx_level), 32'h0);
        check("err_last_byte", 32'(wr_log[wr_log.size() - 1]), 32'hE2);
`ifdef UARTLITE_ERR_CNT_EN
        check("err_cnt_two", 32'(err_cnt), 32'd2);
        check("err_flag_set", {31'b0, err_flag}, 32'h1);
`endif
        bresp_cfg = 2'b00;
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
